// File: rtl/gate_truth_table_checker.sv
// Truth-table sequencer for a single-output combinational gate: walks every input vector,
// samples dut_y after a settle delay, and counts mismatches. Optional GATE_CHK_STOP_ON_FAIL_EN.
module gate_truth_table_checker #(
  parameter int                      N_INPUTS      = 2,
  parameter logic [2**N_INPUTS-1:0]  EXPECTED_TT   = 4'b1000,
  parameter int                      SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_y,
  output logic [N_INPUTS-1:0] vec_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                first_fail_valid,
  output logic [N_INPUTS-1:0] first_fail_vec
);

  localparam int                CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [N_INPUTS-1:0] vec_nxt, ffvec_nxt;
  logic [N_INPUTS:0]   err_nxt;
  logic                ffv_nxt, pass_nxt, mismatch, stop;

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      vec_out          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      vec_out          <= vec_nxt;
      err_count        <= err_nxt;
      first_fail_valid <= ffv_nxt;
      first_fail_vec   <= ffvec_nxt;
      pass             <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec_out;
    err_nxt   = err_count;
    ffv_nxt   = first_fail_valid;
    ffvec_nxt = first_fail_vec;
    pass_nxt  = pass;
    mismatch  = 1'b0;
    stop      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          vec_nxt   = '0;
          err_nxt   = '0;
          ffv_nxt   = 1'b0;
          ffvec_nxt = '0;
          pass_nxt  = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SAMPLE: begin
        mismatch = (dut_y != EXPECTED_TT[vec_out]);
        if (mismatch) begin
          if (err_count != '1) err_nxt = err_count + 1'b1;
          if (!first_fail_valid) begin
            ffv_nxt   = 1'b1;
            ffvec_nxt = vec_out;
          end
        end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        stop = (vec_out == VEC_LAST) || mismatch;
`else
        stop = (vec_out == VEC_LAST);
`endif
        // vec_out is left on the last applied vector when the run ends
        if (stop) begin
          state_nxt = DONE;
          pass_nxt  = (err_nxt == '0);
        end else begin
          vec_nxt   = vec_out + 1'b1;
          state_nxt = DRIVE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomized self-checking bench: a truth-table-driven gate model feeds dut_y and the
// expected run outcome is derived from the XOR of actual vs. expected tables.
module tb_gate_truth_table_checker;
  localparam int            N    = 2;
  localparam int            NV   = 2**N;
  localparam logic [NV-1:0] ETT  = 4'b1000;
  localparam int            SET  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dut_y;
  logic [N-1:0]  vec_out;
  logic          busy, done, pass, first_fail_valid;
  logic [N:0]    err_count;
  logic [N-1:0]  first_fail_vec;
  logic [NV-1:0] gate_tt = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_y = gate_tt[vec_out];

  gate_truth_table_checker #(.N_INPUTS(N), .EXPECTED_TT(ETT), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_y(dut_y), .vec_out(vec_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_vec"}, 32'(vec_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_ffv"}, 32'(first_fail_valid), 0);
    chk({tag, "_ffvec"}, 32'(first_fail_vec), 0);
  endtask

  // Expected outcome from the table difference, then walk the run cycle by cycle.
  task automatic run(input logic [NV-1:0] tt, input bit inject);
    logic [NV-1:0] diff;
    int exp_err, exp_ff, last_v, n, dcnt;
    diff    = tt ^ ETT;
    exp_err = $countones(diff);
    exp_ff  = 0;
    for (int i = NV - 1; i >= 0; i--) if (diff[i]) exp_ff = i;
    last_v  = NV - 1;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    if (exp_err != 0) begin
      exp_err = 1;
      last_v  = exp_ff;
    end
`endif
    @(negedge clk);
    gate_tt = tt;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    dcnt = 0;
    while (busy && n < 200) begin
      chk("vec_seq", 32'(vec_out), 32'(n / (SET + 1)));
      if (done) dcnt++;
      start = inject && (n == 4);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", 32'(n), 32'((last_v + 1) * (SET + 1)));
    chk("done_in_busy", 32'(dcnt), 0);
    chk("done_pulse", 32'(done), 1);
    chk("pass", 32'(pass), 32'(exp_err == 0));
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("ffv", 32'(first_fail_valid), 32'(exp_err != 0));
    chk("ffvec", 32'(first_fail_vec), 32'(exp_err != 0 ? exp_ff : 0));
    chk("vec_final", 32'(vec_out), 32'(last_v));
    @(negedge clk);
    chk("done_end", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("pass_hold", 32'(pass), 32'(exp_err == 0));
    chk("err_hold", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    int n;
    #1;
    chk_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'b1000, 1'b0);   // correct AND
    run(4'b0000, 1'b0);   // tied 0
    run(4'b1110, 1'b0);   // OR
    run(4'b1000, 1'b1);   // start re-pulsed while busy
    run(4'b1111, 1'b0);   // tied 1

    // asynchronous reset in the middle of a run
    @(negedge clk);
    gate_tt = 4'b1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_out != 2'b10 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("reach_vec2", 32'(vec_out), 2);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(4'b1000, 1'b0);

    for (int k = 0; k < 10; k++) run(NV'($urandom), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
